// File: rtl/aes_key_pkg.sv
// AES-128 key schedule shared types: sizes, FSM state encoding, GF(2^8) and S-box helpers.
// Latency: n/a (constants and purely combinational functions).
// Backpressure: n/a.
package aes_key_pkg;

    localparam int KEY_W      = 128;
    localparam int NUM_ROUNDS = 10;
    localparam int NUM_RKEYS  = 11;
    localparam int RC_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        FINISH = 2'd2
    } key_sched_state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // Inverse computed as x^254 through a fixed addition chain; x=0 maps to 0,
    // which is exactly what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // Affine transform: v ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [RC_W-1:0] rc);
        logic [7:0] r;
        case (rc)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Control/read bundle between a key-schedule user and key_schedule_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored by the slave while busy.
// master: drives start, key_in, rd_addr; slave: drives rd_key, busy, done, keys_valid, round.
interface key_schedule_ctrl_if ();

    logic                           start;
    logic [aes_key_pkg::KEY_W-1:0]  key_in;
    logic [3:0]                     rd_addr;
    logic [aes_key_pkg::KEY_W-1:0]  rd_key;
    logic                           busy;
    logic                           done;
    logic                           keys_valid;
    logic [aes_key_pkg::RC_W-1:0]   round;

    modport master (
        output start, key_in, rd_addr,
        input  rd_key, busy, done, keys_valid, round
    );

    modport slave (
        input  start, key_in, rd_addr,
        output rd_key, busy, done, keys_valid, round
    );

endinterface

// File: rtl/key_schedule_ctrl_key_expansion.sv
// One AES-128 key-expansion step: next round key from the previous round key and round index.
// Latency: combinational.
// Backpressure: none.
// Ports: rc (round index 0..9), key (round key rc), sub_key (round key rc+1).
module key_schedule_ctrl_key_expansion
    import aes_key_pkg::*;
(
    input  logic [RC_W-1:0]  rc,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] sub_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;

    // RotWord then SubWord on the last word, round constant into the top byte.
    assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rc), 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign sub_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: expands a cipher key into 11 round keys, one per cycle.
// Latency: done pulses in the cycle after the 10th edge following the start-accepting edge.
// Backpressure: none; start is ignored while busy, key_in is only sampled on acceptance.
// Ports: clk, rst (sync, active-high); bus (slave): start, key_in, rd_addr -> rd_key, busy,
//        done, keys_valid, round. rd_key is a combinational read; rd_addr 11..15 reads 0.
// Build option: define KEY_SCHED_ZEROIZE_EN to clear the key store on rst and on every
//        accepted start (entries 1..10); by default the store has no reset.
module key_schedule_ctrl
    import aes_key_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    key_schedule_ctrl_if.slave bus
);

    key_sched_state_t state;
    logic [RC_W-1:0]  round_q;
    logic             busy_q;
    logic             done_q;
    logic             keys_valid_q;

    logic [KEY_W-1:0] store [NUM_RKEYS];
    logic [KEY_W-1:0] sub_key;
    logic [RC_W-1:0]  wr_idx;
    logic             accept;
    logic             expand_we;

    // rst wins over start; start only counts outside EXPAND.
    assign accept    = !rst && bus.start && ((state == IDLE) || (state == FINISH));
    assign expand_we = !rst && (state == EXPAND);
    assign wr_idx    = round_q + RC_W'(1);

    // round_q never leaves 0..9, so the expansion step only ever sees legal round indices.
    key_schedule_ctrl_key_expansion u_key_expansion (
        .rc      (round_q),
        .key     (store[round_q]),
        .sub_key (sub_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            round_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    round_q <= '0;
                    if (accept) begin
                        state        <= EXPAND;
                        busy_q       <= 1'b1;
                        keys_valid_q <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXPAND: begin
                    if (round_q == RC_W'(NUM_ROUNDS - 1)) begin
                        // This edge writes round key 10; round holds at 9.
                        state        <= FINISH;
                        done_q       <= 1'b1;
                        keys_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        round_q <= round_q + RC_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    round_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
`ifdef KEY_SCHED_ZEROIZE_EN
        if (rst) begin
            for (int i = 0; i < NUM_RKEYS; i++) store[i] <= '0;
        end else
`endif
        if (accept) begin
            store[0] <= bus.key_in;
`ifdef KEY_SCHED_ZEROIZE_EN
            for (int i = 1; i < NUM_RKEYS; i++) store[i] <= '0;
`endif
        end else if (expand_we) begin
            store[wr_idx] <= sub_key;
        end
    end

    assign bus.rd_key     = (bus.rd_addr < 4'(NUM_RKEYS)) ? store[bus.rd_addr] : '0;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.round      = round_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl: stimulus queues expected round-key sets,
// a monitor pops one per done pulse and sweeps every read address.
// Reference: word-oriented AES-128 expansion with a brute-force-inverse S-box table.
module tb_key_schedule_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef logic [10:0][127:0] rk_set_t;
    typedef struct packed {
        rk_set_t     rk;
        logic [31:0] done_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] sb [256];
    logic       stim_owns = 1'b0;
    logic [3:0] stim_addr = 4'd0;
    logic [3:0] mon_addr  = 4'd0;

    localparam logic [127:0] VEC_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] VEC_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] VEC_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    key_schedule_ctrl_if bus ();
    assign bus.rd_addr = stim_owns ? stim_addr : mon_addr;

    key_schedule_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if (x[8]) x = x ^ 'h11b;
        end
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            int         inv;
            logic [7:0] v;
            logic [7:0] s;
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && ref_mul(8'(x), 8'(y)) == 8'h01) inv = y;
            v = 8'(inv);
            for (int i = 0; i < 8; i++)
                s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic rk_set_t ref_schedule(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_set_t     rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = ref_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return rk;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic stim_read(input logic [3:0] a, output logic [127:0] d);
        stim_owns = 1'b1;
        stim_addr = a;
        #1;
        d = bus.rd_key;
        stim_owns = 1'b0;
    endtask

    // Issue one start pulse; DUT must be idle at the upcoming edge.
    task automatic start_run(input logic [127:0] key);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.key_in = key;
        e.rk       = ref_schedule(key);
        e.done_cyc = 32'(cyc + 11);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.busy && bus.round == r) && n < 40);
        check("reach_round", 128'(bus.round), 128'(r));
        check("busy_mid_run", 128'(bus.busy), 128'(1));
        check("kv_low_mid_run", 128'(bus.keys_valid), 128'(0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || bus.done) && n < 40);
        check("run_completes", 128'(bus.busy), 128'(0));
    endtask

    // Monitor: one expected entry per done pulse.
    initial begin
        exp_t         e;
        logic [127:0] want;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending run", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_latency", 128'(cyc), 128'(e.done_cyc));
                    check("finish_keys_valid", 128'(bus.keys_valid), 128'(1));
                    check("finish_busy", 128'(bus.busy), 128'(0));
                    for (int a = 0; a < 16; a++) begin
                        mon_addr = 4'(a);
                        #1;
                        want = (a < 11) ? e.rk[a] : '0;
                        check($sformatf("rd_key[%0d]", a), bus.rd_key, want);
                    end
                end
            end
        end
    end

    initial begin
        logic [127:0] d;
        logic [127:0] k1;
        logic [127:0] k2;
        exp_t         e;
        logic         do_rst;
        logic         rst_hit;
        logic [3:0]   rst_round;
        int           n;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.key_in = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_done", 128'(bus.done), 128'(0));
        check("rst_keys_valid", 128'(bus.keys_valid), 128'(0));
        check("rst_round", 128'(bus.round), 128'(0));
`ifdef KEY_SCHED_ZEROIZE_EN
        for (int a = 0; a < 11; a++) begin
            stim_read(4'(a), d);
            check("zeroise_after_rst", d, '0);
        end
`endif

        // Known-answer vector.
        start_run(VEC_KEY);
        wait_idle();
        stim_read(4'd1, d);
        check("vec_rk1", d, VEC_RK1);
        stim_read(4'd10, d);
        check("vec_rk10", d, VEC_RK10);
        check("vec_keys_valid", 128'(bus.keys_valid), 128'(1));

        // Second start with a different key while busy must be ignored.
        start_run(VEC_KEY);
        wait_round(4'd4);
        bus.start  = 1'b1;
        bus.key_in = ~VEC_KEY;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_idle();
        stim_read(4'd1, d);
        check("busy_start_rk1", d, VEC_RK1);
        stim_read(4'd10, d);
        check("busy_start_rk10", d, VEC_RK10);

        for (int a = 11; a < 16; a++) begin
            stim_read(4'(a), d);
            check("oob_read", d, '0);
        end

        // Reset in the middle of an expansion.
        start_run({$urandom, $urandom, $urandom, $urandom});
        wait_round(4'd5);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 128'(bus.busy), 128'(0));
        check("midrst_keys_valid", 128'(bus.keys_valid), 128'(0));
        check("midrst_done", 128'(bus.done), 128'(0));
        check("midrst_round", 128'(bus.round), 128'(0));
`ifdef KEY_SCHED_ZEROIZE_EN
        for (int a = 0; a < 11; a++) begin
            stim_read(4'(a), d);
            check("zeroise_mid_rst", d, '0);
        end
`endif
        start_run({$urandom, $urandom, $urandom, $urandom});
        wait_idle();
        check("after_rst_keys_valid", 128'(bus.keys_valid), 128'(1));

        // start held high through FINISH: second run starts from FINISH.
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.key_in = k1;
        e.rk       = ref_schedule(k1);
        e.done_cyc = 32'(cyc + 11);
        exp_q.push_back(e);
        e.rk       = ref_schedule(k2);
        e.done_cyc = 32'(cyc + 22);
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.key_in = k2;
        repeat (11) @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("b2b_busy", 128'(bus.busy), 128'(1));
        check("b2b_keys_valid", 128'(bus.keys_valid), 128'(0));
        check("b2b_round", 128'(bus.round), 128'(0));
        wait_idle();
        check("b2b_final_keys_valid", 128'(bus.keys_valid), 128'(1));

        // Randomized runs with ignored starts and occasional mid-run resets.
        for (int it = 0; it < 24; it++) begin
            do_rst    = ($urandom_range(0, 4) == 0);
            rst_round = 4'($urandom_range(0, 9));
            rst_hit   = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            start_run({$urandom, $urandom, $urandom, $urandom});
            n = 0;
            while (n < 40 && !rst_hit) begin
                @(negedge clk);
                n++;
                if (!bus.busy) break;
                if (do_rst && bus.round == rst_round) begin
                    rst = 1'b1;
                    exp_q.delete();
                    rst_hit = 1'b1;
                    @(posedge clk);
                    #1 rst = 1'b0;
                    @(negedge clk);
                    check("rand_rst_busy", 128'(bus.busy), 128'(0));
`ifdef KEY_SCHED_ZEROIZE_EN
                    stim_read(4'($urandom_range(0, 10)), d);
                    check("rand_zeroise", d, '0);
`endif
                end else if (bus.round <= 4'd7 && $urandom_range(0, 3) == 0) begin
                    bus.start  = 1'b1;
                    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
                    @(posedge clk);
                    #1 bus.start = 1'b0;
                end
            end
            @(negedge clk);
            check("rand_end_busy", 128'(bus.busy), 128'(0));
            check("rand_keys_valid", 128'(bus.keys_valid), rst_hit ? 128'(0) : 128'(1));
            stim_read(4'($urandom_range(11, 15)), d);
            check("rand_oob_read", d, '0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
